// File: rtl/cordic_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched_if
// Description : Request, response and core-side bundle for cordic_sched.
//               The slave modport is the scheduler; the master modport is
//               the surrounding environment (requesters, consumer, core).
//               Optional CORDIC_SCHED_STATS_EN adds the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_sched_if #(
  parameter int WHOLE_BIT_WIDTH   = 3,
  parameter int DECIMAL_BIT_WIDTH = 5,
  parameter int NUM_REQ           = 4
);
  localparam int W  = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH;
  localparam int IW = $clog2(NUM_REQ);

  // Request side
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_x;
  logic [NUM_REQ*W-1:0] req_y;
  logic [NUM_REQ*W-1:0] req_z;
  logic [NUM_REQ-1:0]   req_mode;
  logic [2*NUM_REQ-1:0] req_coord;

  // Response side
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IW-1:0]        resp_id;
  logic                 resp_err;
  logic [W-1:0]         resp_x;
  logic [W-1:0]         resp_y;
  logic [W-1:0]         resp_z;

  // Shared CORDIC core side
  logic [WHOLE_BIT_WIDTH-1:0]   core_x_whole;
  logic [WHOLE_BIT_WIDTH-1:0]   core_y_whole;
  logic [WHOLE_BIT_WIDTH-1:0]   core_z_whole;
  logic [DECIMAL_BIT_WIDTH-1:0] core_x_decimal;
  logic [DECIMAL_BIT_WIDTH-1:0] core_y_decimal;
  logic [DECIMAL_BIT_WIDTH-1:0] core_z_decimal;
  logic                         core_mode;
  logic [1:0]                   core_coord;
  logic                         core_rst;
  logic [W-1:0]                 core_x_out;
  logic [W-1:0]                 core_y_out;
  logic [W-1:0]                 core_z_out;

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] done_cnt;
  logic [7:0]  err_cnt;
`endif

  modport slave (
    input  req_valid, req_x, req_y, req_z, req_mode, req_coord,
    output req_ready,
    output resp_valid, resp_id, resp_err, resp_x, resp_y, resp_z,
    input  resp_ready,
    output core_x_whole, core_y_whole, core_z_whole,
    output core_x_decimal, core_y_decimal, core_z_decimal,
    output core_mode, core_coord, core_rst,
    input  core_x_out, core_y_out, core_z_out
`ifdef CORDIC_SCHED_STATS_EN
    , output done_cnt, err_cnt
`endif
  );

  modport master (
    output req_valid, req_x, req_y, req_z, req_mode, req_coord,
    input  req_ready,
    input  resp_valid, resp_id, resp_err, resp_x, resp_y, resp_z,
    output resp_ready,
    input  core_x_whole, core_y_whole, core_z_whole,
    input  core_x_decimal, core_y_decimal, core_z_decimal,
    input  core_mode, core_coord, core_rst,
    output core_x_out, core_y_out, core_z_out
`ifdef CORDIC_SCHED_STATS_EN
    , input done_cnt, err_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched
// Description : Round-robin scheduler sharing one iterative CORDIC core among
//               NUM_REQ requesters. Grants in IDLE, loads the core (held in
//               reset with stable operands) in LOAD, lets it iterate for
//               ITER_CYCLES cycles in RUN, then presents the captured result
//               in RESP until the consumer accepts it. Illegal coord (2'b10)
//               skips the core and answers with resp_err and zero results.
//               Optional macro CORDIC_SCHED_STATS_EN adds done_cnt (16-bit,
//               wrapping) and err_cnt (8-bit, saturating) outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_sched #(
  parameter int WHOLE_BIT_WIDTH   = 3,
  parameter int DECIMAL_BIT_WIDTH = 5,
  parameter int NUM_REQ           = 4,
  parameter int ITER_CYCLES       = 16
) (
  input  logic          clk,
  input  logic          rst,
  cordic_sched_if.slave bus
);
  localparam int W  = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ITER_CYCLES) + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER_CYCLES - 1);
  localparam logic [1:0]    COORD_ILLEGAL = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [W-1:0]       x_q, y_q, z_q;
  logic               mode_q;
  logic [1:0]         coord_q;
  logic [IW-1:0]      id_q;
  logic               err_q;
  logic [W-1:0]       rx_q, ry_q, rz_q;

  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic [IW:0]        cand;
  logic               req_hs;
  logic               resp_hs;
  logic               cnt_done;
  logic [1:0]         sel_coord;
  logic [NUM_REQ-1:0] ready_vec;

  // Search for the first valid requester at or above rr_ptr, wrapping round
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_found && bus.req_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // Accepting only in IDLE; rst gating keeps req_ready low throughout reset
  assign req_hs    = (state_q == ST_IDLE) && grant_found && rst;
  assign resp_hs   = (state_q == ST_RESP) && bus.resp_ready;
  assign cnt_done  = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign sel_coord = bus.req_coord[grant_idx*2 +: 2];
  assign rr_ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // One-hot ready for the granted requester only
  always_comb begin
    ready_vec = '0;
    if (req_hs) ready_vec[grant_idx] = 1'b1;
  end

  // Next-state and iteration counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) state_d = (sel_coord == COORD_ILLEGAL) ? ST_RESP : ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_hs) rr_ptr_q <= rr_ptr_d;
    end
  end

  // Latch the winner's operands on the request handshake; they drive the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      coord_q <= '0;
      id_q    <= '0;
    end else if (req_hs) begin
      x_q     <= bus.req_x[grant_idx*W +: W];
      y_q     <= bus.req_y[grant_idx*W +: W];
      z_q     <= bus.req_z[grant_idx*W +: W];
      mode_q  <= bus.req_mode[grant_idx];
      coord_q <= sel_coord;
      id_q    <= grant_idx;
    end
  end

  // Results cleared on accept (so the error path returns zeros), captured at end of RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_q  <= '0;
      ry_q  <= '0;
      rz_q  <= '0;
      err_q <= 1'b0;
    end else if (req_hs) begin
      rx_q  <= '0;
      ry_q  <= '0;
      rz_q  <= '0;
      err_q <= (sel_coord == COORD_ILLEGAL);
    end else if (cnt_done) begin
      rx_q <= bus.core_x_out;
      ry_q <= bus.core_y_out;
      rz_q <= bus.core_z_out;
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_x     = rx_q;
  assign bus.resp_y     = ry_q;
  assign bus.resp_z     = rz_q;

  // The core only iterates in RUN; everywhere else it is held in load/reset
  assign bus.core_rst       = (state_q != ST_RUN);
  assign bus.core_mode      = mode_q;
  assign bus.core_coord     = coord_q;
  assign bus.core_x_whole   = x_q[W-1 -: WHOLE_BIT_WIDTH];
  assign bus.core_y_whole   = y_q[W-1 -: WHOLE_BIT_WIDTH];
  assign bus.core_z_whole   = z_q[W-1 -: WHOLE_BIT_WIDTH];
  assign bus.core_x_decimal = x_q[DECIMAL_BIT_WIDTH-1:0];
  assign bus.core_y_decimal = y_q[DECIMAL_BIT_WIDTH-1:0];
  assign bus.core_z_decimal = z_q[DECIMAL_BIT_WIDTH-1:0];

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] done_cnt_q;
  logic [7:0]  err_cnt_q;

  // Count accepted responses: good ones wrap, error ones saturate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (resp_hs) begin
      if (err_q) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
      end else begin
        done_cnt_q <= done_cnt_q + 1'b1;
      end
    end
  end

  assign bus.done_cnt = done_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_sched
// Description : Self-checking bench for cordic_sched with a behavioural core
//               stand-in. Core results: x+1, y + x*z (fixed point), ~z, valid
//               only once the core has iterated ITER-1 edges out of reset.
//               Stats checks are compiled when CORDIC_SCHED_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sched;
  localparam int WB   = 3;
  localparam int DB   = 5;
  localparam int W    = WB + DB;
  localparam int NR   = 4;
  localparam int ITER = 16;

  typedef struct {
    int         id;
    logic [7:0] x, y, z;
    logic       mode;
    logic [1:0] coord;
    logic       err;
    logic [7:0] ex, ey, ez;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  cordic_sched_if #(.WHOLE_BIT_WIDTH(WB), .DECIMAL_BIT_WIDTH(DB), .NUM_REQ(NR)) bif ();

  cordic_sched #(
    .WHOLE_BIT_WIDTH(WB), .DECIMAL_BIT_WIDTH(DB), .NUM_REQ(NR), .ITER_CYCLES(ITER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  // Behavioural core stand-in
  logic signed [W-1:0]   m_cx, m_cy, m_cz;
  logic signed [2*W-1:0] m_prod;
  int                    m_it = 0;
  logic                  m_ok;
  assign m_cx   = {bif.core_x_whole, bif.core_x_decimal};
  assign m_cy   = {bif.core_y_whole, bif.core_y_decimal};
  assign m_cz   = {bif.core_z_whole, bif.core_z_decimal};
  assign m_prod = m_cx * m_cz;
  assign m_ok   = (m_it >= ITER - 1) && !bif.core_rst;
  assign bif.core_x_out = m_ok ? m_cx + 8'sd1 : '0;
  assign bif.core_y_out = m_ok ? m_cy + m_prod[W-1+DB:DB] : '0;
  assign bif.core_z_out = m_ok ? ~m_cz : '0;
  always @(posedge clk) begin
    if (bif.core_rst) m_it <= 0;
    else if (m_it < 1000) m_it <= m_it + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load_slot(input vec_t v);
    bif.req_x[v.id*W +: W]     = v.x;
    bif.req_y[v.id*W +: W]     = v.y;
    bif.req_z[v.id*W +: W]     = v.z;
    bif.req_mode[v.id]         = v.mode;
    bif.req_coord[v.id*2 +: 2] = v.coord;
  endtask

  task automatic run_vec(input vec_t v);
    int wt, lat, low;
    load_slot(v);
    bif.req_valid[v.id] = 1'b1;
    #1;
    wt = 0;
    while (bif.req_ready[v.id] !== 1'b1 && wt < 50) begin
      tick();
      #1;
      wt++;
    end
    check("grant_onehot", 32'(bif.req_ready), 32'd1 << v.id);
    tick();
    bif.req_valid[v.id] = 1'b0;
    #1;
    check("cycle1_core_rst", 32'(bif.core_rst), 1);
    check("core_x_operand", {bif.core_x_whole, bif.core_x_decimal}, v.x);
    check("core_y_operand", {bif.core_y_whole, bif.core_y_decimal}, v.y);
    check("core_z_operand", {bif.core_z_whole, bif.core_z_decimal}, v.z);
    check("core_mode_coord", {bif.core_mode, bif.core_coord}, {v.mode, v.coord});
    lat = 1;
    low = 0;
    while (bif.resp_valid !== 1'b1 && lat < 40) begin
      if (bif.core_rst === 1'b0) low++;
      tick();
      #1;
      lat++;
    end
    check("resp_latency", lat, v.err ? 1 : ITER + 2);
    check("core_rst_low_cycles", low, v.err ? 0 : ITER);
    check("resp_core_rst", 32'(bif.core_rst), 1);
    check("resp_id", 32'(bif.resp_id), v.id);
    check("resp_err", 32'(bif.resp_err), 32'(v.err));
    check("resp_x", 32'(bif.resp_x), 32'(v.ex));
    check("resp_y", 32'(bif.resp_y), 32'(v.ey));
    check("resp_z", 32'(bif.resp_z), 32'(v.ez));
    tick();
    check("resp_drop", 32'(bif.resp_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order[5];
    int g, t, last, wt;
    logic [26:0] snap;

    //           id  x      y      z      md    crd    err   ex     ey     ez
    vecs[0] = '{0, 8'h30, 8'h00, 8'h40, 1'b0, 2'b00, 1'b0, 8'h31, 8'h60, 8'hBF};
    vecs[1] = '{1, 8'h20, 8'h10, 8'h20, 1'b1, 2'b01, 1'b0, 8'h21, 8'h30, 8'hDF};
    vecs[2] = '{2, 8'h55, 8'h66, 8'h77, 1'b0, 2'b10, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{3, 8'hF0, 8'h08, 8'h40, 1'b1, 2'b11, 1'b0, 8'hF1, 8'hE8, 8'hBF};
    vecs[4] = '{0, 8'h10, 8'h00, 8'h10, 1'b0, 2'b01, 1'b0, 8'h11, 8'h08, 8'hEF};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state, with requests pending to show req_ready is forced low
    rst            = 1'b0;
    bif.req_valid  = '1;
    bif.req_x      = '0;
    bif.req_y      = '0;
    bif.req_z      = '0;
    bif.req_mode   = '0;
    bif.req_coord  = '0;
    bif.resp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(bif.req_ready), 0);
    check("rst_resp_valid", 32'(bif.resp_valid), 0);
    check("rst_resp_err", 32'(bif.resp_err), 0);
    check("rst_resp_id", 32'(bif.resp_id), 0);
    check("rst_core_rst", 32'(bif.core_rst), 1);
    check("rst_resp_xyz", {bif.resp_x, bif.resp_y, bif.resp_z}, 0);
    rst           = 1'b1;
    bif.req_valid = '0;
    #1;

    // Directed vector table
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Round robin with every requester held valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v    = vecs[0];
      v.id = i;
      load_slot(v);
    end
    bif.req_valid = '1;
    #1;
    g = 0; t = 0; last = -1;
    while (g < 5 && t < 200) begin
      if (bif.req_ready != 0) begin
        check("rr_grant", 32'(bif.req_ready), 32'd1 << exp_order[g]);
        g++;
        tick();
        #1;
        t++;
        check("rr_ready_pulse", 32'(bif.req_ready), 0);
      end
      if (bif.resp_valid === 1'b1) begin
        if (last >= 0) check("rr_resp_spacing", t - last, ITER + 3);
        last = t;
      end
      tick();
      #1;
      t++;
    end
    check("rr_grant_count", g, 5);

    // Back-pressure: hold RESP, requester 1 waits
    do_reset();
    load_slot(vecs[0]);
    load_slot(vecs[1]);
    bif.req_valid  = 4'b0001;
    bif.resp_ready = 1'b0;
    #1;
    check("bp_grant0", 32'(bif.req_ready), 1);
    tick();
    bif.req_valid = 4'b0010;
    #1;
    wt = 0;
    while (bif.resp_valid !== 1'b1 && wt < 40) begin
      tick();
      #1;
      wt++;
    end
    check("bp_resp_valid", 32'(bif.resp_valid), 1);
    check("bp_resp_y", 32'(bif.resp_y), 32'h60);
    snap = {bif.resp_id, bif.resp_err, bif.resp_x, bif.resp_y, bif.resp_z};
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      check("bp_hold", {bif.resp_valid, bif.resp_id, bif.resp_err, bif.resp_x, bif.resp_y, bif.resp_z},
            {1'b1, snap});
      check("bp_no_ready", 32'(bif.req_ready), 0);
    end
    bif.resp_ready = 1'b1;
    tick();
    #1;
    check("bp_grant1_after_release", 32'(bif.req_ready), 32'b0010);

    // Reset at RUN cycle 5 of requester 1 (pointer now at 2)
    tick();
    bif.req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    bif.req_valid = '1;
    #1;
    check("mid_run_core_rst", 32'(bif.core_rst), 0);
    rst = 1'b0;
    #1;
    check("async_core_rst", 32'(bif.core_rst), 1);
    check("async_resp_valid", 32'(bif.resp_valid), 0);
    check("async_req_ready", 32'(bif.req_ready), 0);
    tick();
    tick();
    check("held_req_ready", 32'(bif.req_ready), 0);
    rst = 1'b1;
    #1;
    check("post_rst_grant0", 32'(bif.req_ready), 1);
    check("post_rst_no_resp", 32'(bif.resp_valid), 0);
    bif.req_valid = '0;

`ifdef CORDIC_SCHED_STATS_EN
    do_reset();
    #1;
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    check("stats_done_cnt", 32'(bif.done_cnt), 3);
    check("stats_err_cnt", 32'(bif.err_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cordic_sched.md
# cordic_sched

Round-robin scheduler that shares one iterative `cordic_comp` core among `NUM_REQ` requesters. Each requester supplies x/y/z operands, mode and coordinate system over a valid/ready handshake. The block arbitrates, loads the core by holding it in reset with stable operands, lets it iterate a fixed number of cycles, captures x/y/z, and returns them with the requester ID over a valid/ready response channel. It sits between the request sources and the single CORDIC datapath.

## Interface
- `WHOLE_BIT_WIDTH`, 3, integer bits per operand (minimum 2).
- `DECIMAL_BIT_WIDTH`, 5, fraction bits per operand.
- `NUM_REQ`, 4, number of requesters (2..8).
- `ITER_CYCLES`, 16, cycles the core runs after load before outputs are captured (minimum 1).
- W below = `WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH`; IW = `$clog2(NUM_REQ)`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_x`, `req_y`, `req_z`  in  NUM_REQ*W  operands, requester i at bits [i*W +: W], whole part in the MSBs.
- `req_mode`  in  NUM_REQ  0 = rotation, 1 = vectoring.
- `req_coord`  in  2*NUM_REQ  0 = linear, 1 = circular, 2'b11 = hyperbolic, 2'b10 = illegal.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  IW  index of the served requester.
- `resp_err`  out  1  request carried illegal coord.
- `resp_x`, `resp_y`, `resp_z`  out  W  captured results.
- `core_x_whole`, `core_y_whole`, `core_z_whole`  out  WHOLE_BIT_WIDTH  core operand whole parts.
- `core_x_decimal`, `core_y_decimal`, `core_z_decimal`  out  DECIMAL_BIT_WIDTH  core operand fraction parts.
- `core_mode`  out  1  to core mode bit.
- `core_coord`  out  2  to core coordinate system.
- `core_rst`  out  1  active-high core reset/load.
- `core_x_out`, `core_y_out`, `core_z_out`  in  W  core results.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` high, searching upward from `rr_ptr` with wrap-around.
  - `req_ready` is combinational and is high only for the granted index.
  - The handshake occurs when `req_valid` and `req_ready` are both high. On that edge, latch operands, mode, coord and ID, and set `rr_ptr` = winner+1 mod `NUM_REQ`.
  - Next state is RESP with `resp_err`=1 if coord = 2'b10, otherwise LOAD.
- LOAD: one cycle. `core_rst`=1 and the latched operands drive the core ports. Next state is RUN, with `cnt` cleared.
- RUN: `core_rst`=0 and `cnt` increments each cycle. When `cnt` = `ITER_CYCLES`-1, capture the core outputs into `resp_x/y/z` and go to RESP.
- RESP: `resp_valid`=1. `resp_*` stay stable until `resp_ready` is high. On that handshake, return to IDLE.
- Error path: `resp_x/y/z` = 0, the core is not run, and `core_rst` stays 1.
- `core_rst`=1 in IDLE, LOAD and RESP; it is 0 only in RUN.
- Core operand ports always reflect the latched registers.
- Requests are not accepted outside IDLE. Unserved `req_valid` must be held by the requester.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE and `rr_ptr`=0.
  - All latched and result registers go to 0.
  - `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_id`=0, `core_rst`=1.
  - `req_ready` is forced 0 while `rst` is low.
- Reset mid-operation: the operation is dropped, no response is produced, and the core is held in reset.
- Latency from request handshake edge E0:
  - LOAD during cycle E0+1.
  - RUN for `ITER_CYCLES` cycles.
  - `resp_valid` rises at edge E0+`ITER_CYCLES`+2. With the default this is 18 cycles.
  - Error requests: `resp_valid` rises at edge E0+1.
- Throughput: one request per `ITER_CYCLES`+3 cycles when `resp_ready` is held high.
- A request presented during RESP is granted in the IDLE cycle after the response handshake.
- Back-pressure: `resp_ready` low holds RESP indefinitely. Outputs must not change while held.

## Configuration
- `CORDIC_SCHED_STATS_EN`
  - Defined: adds output `done_cnt` (16 bits, reset 0). It increments on every response handshake with `resp_err`=0, wraps 0xFFFF→0, and a separate 8-bit `err_cnt` saturates at 0xFF.
  - Undefined: neither port nor counters exist, and behaviour is otherwise identical.

## Test plan
- Linear rotation, requester 0: x=0x30 (1.5), y=0, z=0x40 (2.0), mode 0, coord 0 → `resp_valid` at E0+18, `resp_id`=0, `resp_y` within ±2 LSB of 0x60, `core_rst` high exactly during IDLE/LOAD/RESP.
- All four `req_valid` held high, `resp_ready`=1 → grants in order 0,1,2,3,0. Each `req_ready` is a single-cycle one-hot pulse, and responses are 19 cycles apart.
- Requester 2 with coord 2'b10 → `resp_valid` at E0+1, `resp_err`=1, `resp_x/y/z`=0, `core_rst` never low.
- `resp_ready` low for 10 cycles in RESP → `resp_*` stable, all `req_ready`=0, and the pending request on requester 1 is granted the cycle after release.
- Drive `rst` low at RUN cycle 5 → immediately `core_rst`=1, `resp_valid`=0, `req_ready`=0. After release, first grant goes to requester 0.
- With `CORDIC_SCHED_STATS_EN`: 3 good plus 1 illegal request → `done_cnt`=3, `err_cnt`=1.
